seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Multiplexed 7-segment display driver. It consumes the slow scan strobe that the clock divider produces on its o_delayClock output. It accepts a multi-digit hex value through a valid/ready handshake and double-buffers it so updates only take effect at frame boundaries. It scans one digit per strobe and inserts a short all-off blanking gap at every digit switch to prevent ghosting.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
BLANK_CYCLES, 2, i_clk cycles of all-anodes-off between digits (>=1; must be shorter than the strobe period)
ACTIVE_LOW_SEG, 1, 1 = segment and dp outputs are active-low
ACTIVE_LOW_AN, 1, 1 = anode outputs are active-low

Ports:
i_clk  in  1  system clock; single clock domain
i_rst  in  1  synchronous, active-high reset
i_delayClock  in  1  scan strobe from the divider, synchronous to i_clk; each rising edge advances the scan
i_value  in  4*DIGITS  hex nibbles; digit k = i_value[4k+3:4k]
i_dp  in  DIGITS  decimal point per digit
i_valid  in  1  i_value/i_dp valid
o_ready  out  1  pending buffer empty; can accept
o_seg  out  7  segments, bit0=a ... bit6=g
o_dp  out  1  decimal point of the displayed digit
o_an  out  DIGITS  digit enables, one-hot when showing
o_frameDone  out  1  one-cycle pulse on scan wrap

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst is synchronous and active-high. All registers update on posedge i_clk only.
- Edge detect: r_prev <= i_delayClock (reset 0). tick = i_delayClock & ~r_prev. A level held high yields exactly one tick. A high level at reset release yields a tick on the first cycle, which is ignored because the block is in BLANK.
- Buffers: shadow (displayed) and pending (next), each 4*DIGITS value bits plus DIGITS dp bits.
  - Reset: shadow = all zero; pending empty; o_ready = 1.
  - Accept on i_valid & o_ready: pending captured, marked full, o_ready = 0 from the next cycle.
  - i_valid while o_ready = 0 is ignored; the source must hold.
- FSM states: BLANK, SHOW. Reset: state BLANK, idx 0, blank counter 0.
  - BLANK: counter increments each cycle. When it reaches BLANK_CYCLES-1, go to SHOW and clear the counter. Ticks in BLANK are dropped.
  - SHOW: on tick, go to BLANK and advance idx.
    - If idx == DIGITS-1: idx <= 0 and o_frameDone pulses one cycle. If pending is full, shadow <= pending and pending is marked empty, in the same cycle.
    - Otherwise: idx <= idx+1.
- Simultaneous events:
  - Accept and frame load in the same cycle cannot collide, because accept requires pending empty while load requires pending full.
  - A value accepted in the same cycle as a wrap with pending empty goes to pending and waits one full frame.
- Outputs are registered; each reflects the FSM/idx/shadow of the previous cycle (1-cycle latency).
  - BLANK: o_an all inactive, o_seg all inactive, o_dp inactive.
  - SHOW: o_an is active only at bit idx; o_seg = decode(shadow nibble idx); o_dp = shadow dp[idx].
- Decode table, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. The polarity parameter inverts the result.
- Reset values: o_an all inactive, o_seg all inactive, o_dp inactive, o_ready 1, o_frameDone 0.
- Reset mid-operation: all state returns to reset values on the next edge. Pending data is discarded and shadow is cleared to 0.
- o_frameDone fires on every wrap, whether or not a load occurred.

Test Plan:
(All defaults: DIGITS=4, BLANK_CYCLES=2, active-low.)
- Reset for 2 cycles, then release:
  - During and after reset: o_an=4'b1111, o_seg=7'h7F, o_dp=1, o_ready=1.
  - 3 cycles after release: o_an=4'b1110, o_seg=7'h40 (digit "0").
- i_value=16'h1234, i_dp=4'b0001, one-cycle i_valid:
  - o_ready=0 next cycle; display stays 0000 for the current frame.
  - After the wrap tick: o_frameDone pulses once; o_ready=1.
  - Digit 0 then shows o_seg=7'h19 ("4") with o_dp=0.
  - Digit 1 shows 7'h30 ("3").
- Hex sweep: load each nibble 0..F into digit 0 and let it display. o_seg must equal the inverted table, e.g. 8 -> 7'h00, F -> 7'h0E, b -> 7'h03.
- Hold i_delayClock high for 10 cycles -> exactly one idx advance. Raise a tick 1 cycle after entering BLANK -> it is dropped and idx is unchanged.
- Second i_valid while pending is full -> ignored. The held value is accepted only after the next frame load raises o_ready.
- Load 16'hABCD, then assert i_rst mid-scan at idx=2 before the wrap:
  - Next cycle: all outputs return to reset values and o_ready=1.
  - Afterwards the display shows 0000, not ABCD.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: double-buffered hex value, one digit per
// scan strobe, all-off blanking gap at every digit switch.
module seg7_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter bit          ACTIVE_LOW_SEG = 1'b1,
    parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_delayClock,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [DIGITS-1:0]     o_an,
    output logic                  o_frameDone
);
    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned CNT_W = $clog2(BLANK_CYCLES + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [6:0]        SEG_OFF  = {7{ACTIVE_LOW_SEG}};
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW_AN}};

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                prev_q;
    logic [VAL_W-1:0]    shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [VAL_W-1:0]    pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                pend_full_q, pend_full_d;
    logic                ready_q, ready_d;
    logic                frame_q, frame_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                tick_c;
    logic                accept_c;
    logic [3:0]          nib_c;
    logic                dp_sel_c;
    logic [DIGITS-1:0]   onehot_c;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    assign tick_c   = i_delayClock & ~prev_q;
    assign accept_c = i_valid & ready_q;

    // Scan sequencing and buffer management; a frame load only happens on wrap.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_full_d  = pend_full_q;
        frame_d      = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (tick_c) begin
                    state_d = ST_BLANK;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        frame_d = 1'b1;
                        if (pend_full_q) begin
                            shadow_val_d = pend_val_q;
                            shadow_dp_d  = pend_dp_q;
                            pend_full_d  = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_BLANK;
        endcase

        // Accept needs pending empty, load needs it full: the two never collide.
        if (accept_c) begin
            pend_val_d  = i_value;
            pend_dp_d   = i_dp;
            pend_full_d = 1'b1;
        end
        ready_d = ~pend_full_d;
    end

    always_comb begin
        nib_c    = '0;
        dp_sel_c = 1'b0;
        onehot_c = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_c       = shadow_val_q[4*k +: 4];
                dp_sel_c    = shadow_dp_q[k];
                onehot_c[k] = 1'b1;
            end
        end

        if (state_q == ST_SHOW) begin
            an_d  = onehot_c ^ AN_OFF;
            seg_d = decode(nib_c) ^ SEG_OFF;
            dp_d  = dp_sel_c ^ ACTIVE_LOW_SEG;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = ACTIVE_LOW_SEG;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            prev_q       <= 1'b0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_full_q  <= 1'b0;
            ready_q      <= 1'b1;
            frame_q      <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= ACTIVE_LOW_SEG;
            an_q         <= AN_OFF;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            prev_q       <= i_delayClock;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_full_q  <= pend_full_d;
            ready_q      <= ready_d;
            frame_q      <= frame_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_seg       = seg_q;
    assign o_dp        = dp_q;
    assign o_an        = an_q;
    assign o_frameDone = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues the expected digit for
// every scan step, a monitor pops one entry each time a digit lights up.
module tb_seg7_scan_driver;
    localparam int NDIG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dclk;
    logic        valid;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        ready;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS         (4),
        .BLANK_CYCLES   (2),
        .ACTIVE_LOW_SEG (1'b1),
        .ACTIVE_LOW_AN  (1'b1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_delayClock (dclk),
        .i_value      (value),
        .i_dp         (dp_in),
        .i_valid      (valid),
        .o_ready      (ready),
        .o_seg        (seg),
        .o_dp         (dp_out),
        .o_an         (an),
        .o_frameDone  (frame)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         frames;
    } show_t;

    show_t exp_q[$];
    int checks = 0;
    int passes = 0;

    // Expected display contents as seen from outside the DUT.
    int          cur_idx;
    logic [15:0] disp_val;
    logic [3:0]  disp_dp;
    logic [15:0] pend_val;
    logic [3:0]  pend_dp;
    bit          pend_full;

    // Active-low segment patterns, hand-inverted from the gfedcba table.
    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h40;  4'h1: p = 7'h79;  4'h2: p = 7'h24;  4'h3: p = 7'h30;
            4'h4: p = 7'h19;  4'h5: p = 7'h12;  4'h6: p = 7'h02;  4'h7: p = 7'h78;
            4'h8: p = 7'h00;  4'h9: p = 7'h10;  4'hA: p = 7'h08;  4'hB: p = 7'h03;
            4'hC: p = 7'h46;  4'hD: p = 7'h21;  4'hE: p = 7'h06;  default: p = 7'h0E;
        endcase
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic push_show(input int idx, input int frames);
        show_t e;
        e.an     = ~(4'b0001 << idx);
        e.seg    = exp_seg(disp_val[4*idx +: 4]);
        e.dp     = ~disp_dp[idx];
        e.frames = frames;
        exp_q.push_back(e);
    endtask

    task automatic advance_model(output int frames);
        frames = 0;
        if (cur_idx == NDIG - 1) begin
            cur_idx = 0;
            frames  = 1;
            if (pend_full) begin
                disp_val  = pend_val;
                disp_dp   = pend_dp;
                pend_full = 1'b0;
            end
        end else begin
            cur_idx++;
        end
    endtask

    task automatic do_tick();
        int fr;
        advance_model(fr);
        push_show(cur_idx, fr);
        dclk = 1'b1;
        nxt();
        dclk = 1'b0;
        repeat (6) nxt();
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] d);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            nxt();
            n++;
        end
        chk("send_ready", 32'(ready), 32'd1);
        value = v;
        dp_in = d;
        valid = 1'b1;
        nxt();
        valid = 1'b0;
        chk("ready_low_after_accept", 32'(ready), 32'd0);
        pend_val  = v;
        pend_dp   = d;
        pend_full = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"}, 32'(an), 32'hF);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_dp"}, 32'(dp_out), 32'd1);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_frame"}, 32'(frame), 32'd0);
    endtask

    // Monitor: every off-to-on transition of the anodes is one scan step.
    logic [3:0] prev_an = 4'hF;
    int         frame_cnt = 0;
    always @(negedge clk) begin : monitor
        show_t e;
        if (an !== 4'hF && prev_an === 4'hF) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_show", 32'(an), 32'hF);
            end else begin
                e = exp_q.pop_front();
                chk("show_an", 32'(an), 32'(e.an));
                chk("show_seg", 32'(seg), 32'(e.seg));
                chk("show_dp", 32'(dp_out), 32'(e.dp));
                chk("show_frames", 32'(frame_cnt), 32'(e.frames));
            end
            frame_cnt <= 0;
        end else if (frame === 1'b1) begin
            frame_cnt <= frame_cnt + 1;
        end
        prev_an <= an;
    end

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
        $fatal(1);
    end

    initial begin : stim
        int n;
        rst = 1'b1; dclk = 1'b0; valid = 1'b0; value = '0; dp_in = '0;
        cur_idx = 0; disp_val = '0; disp_dp = '0;
        pend_val = '0; pend_dp = '0; pend_full = 1'b0;

        // Reset and first digit.
        nxt();
        chk_reset_outputs("rst_c1");
        nxt();
        chk_reset_outputs("rst_c2");
        push_show(0, 0);
        rst = 1'b0;
        nxt();
        chk_reset_outputs("post_rel");
        nxt();
        nxt();
        chk("first_show_an", 32'(an), 32'hE);
        chk("first_show_seg", 32'(seg), 32'h40);

        // 1234 waits for the frame boundary.
        send(16'h1234, 4'b0001);
        repeat (3) do_tick();
        do_tick();
        chk("ready_after_load", 32'(ready), 32'd1);
        do_tick();

        // Level held high gives one advance.
        advance_model(n);
        push_show(cur_idx, n);
        dclk = 1'b1;
        repeat (10) nxt();
        dclk = 1'b0;
        repeat (6) nxt();

        // Second rising edge while still blanking is dropped.
        advance_model(n);
        push_show(cur_idx, n);
        dclk = 1'b1; nxt();
        dclk = 1'b0; nxt();
        dclk = 1'b1; nxt();
        dclk = 1'b0;
        repeat (6) nxt();
        do_tick();

        // Valid while pending is full is ignored until the next load.
        send(16'h5678, 4'b0010);
        value = 16'h9ABC;
        dp_in = 4'b1000;
        valid = 1'b1;
        nxt();
        nxt();
        chk("ready_held_low", 32'(ready), 32'd0);
        repeat (3) do_tick();
        do_tick();
        chk("held_value_taken", 32'(ready), 32'd0);
        valid = 1'b0;
        pend_val = 16'h9ABC; pend_dp = 4'b1000; pend_full = 1'b1;
        repeat (3) do_tick();
        do_tick();
        chk("ready_after_second_load", 32'(ready), 32'd1);

        // Hex sweep through the decoder.
        for (int h = 0; h < 16; h++) begin
            send({4{4'(h)}}, 4'(h));
            while (cur_idx != NDIG - 1) do_tick();
            do_tick();
        end

        // Reset mid-scan discards pending ABCD and clears the shadow.
        send(16'hABCD, 4'b0000);
        do_tick();
        do_tick();
        rst = 1'b1;
        nxt();
        chk_reset_outputs("mid_rst");
        cur_idx = 0; disp_val = '0; disp_dp = '0; pend_full = 1'b0;
        push_show(0, 0);
        rst = 1'b0;
        repeat (6) nxt();
        repeat (4) do_tick();

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            nxt();
            n++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
